// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared types and constants for the fetch sequencer
package fetch_sequencer_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // A fetched word equal to this value ends the instruction stream.
   localparam logic [DATA_W-1:0] END_MARKER = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] word;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch queue of {pc, word} entries with push/pop/flush
module fetch_queue
   import fetch_sequencer_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  fetch_entry_t              i_push_entry,
   input  logic                      i_pop,
   input  logic                      i_flush,
   output fetch_entry_t              o_head,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(QDEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(QDEPTH);

   fetch_entry_t       r_mem [QDEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = i_push && (r_count != FULL_COUNT);
   assign w_do_pop  = i_pop && (r_count != '0);

   // Flush wins over push and pop; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_entry;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == FULL_COUNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with prefetch queue, redirect and halt
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned RESET_PC  = 100,
   parameter int          QDEPTH    = 4,
   parameter int unsigned MEM_BYTES = 16384
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic [DATA_W-1:0] imemData,
   input  logic              redirectValid,
   input  logic [ADDR_W-1:0] redirectPC,
   output logic              instrValid,
   input  logic              instrReady,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] instrPC,
   output logic              halted,
   output logic              fault
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   state_t             r_state;
   state_t             w_state_next;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pc_next;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic [ADDR_W-1:0]  w_pc_seq;
   logic               r_fault;
   logic               w_set_fault;
   logic               w_push;
   logic               w_pop;
   logic               w_flush;
   logic               w_full;
   logic               w_empty;
   logic               w_valid;
   logic               w_drained;
   logic               w_redirect_ok;
   logic [CNT_W-1:0]   w_count;
   fetch_entry_t       w_head;
   fetch_entry_t       w_push_entry;

   assign w_pc_inc      = r_pc + 32'd4;
   assign w_pc_seq      = (w_pc_inc >= MEM_LIMIT) ? '0 : w_pc_inc;
   assign w_redirect_ok = (redirectPC[1:0] == 2'b00) && (redirectPC < MEM_LIMIT);
   assign w_valid       = !w_empty;
   assign w_pop         = w_valid && instrReady;
   // The queue is empty after this edge either already or because the last entry leaves now.
   assign w_drained     = w_empty || ((w_count == CNT_ONE) && w_pop);

   assign w_push_entry.pc   = r_pc;
   assign w_push_entry.word = imemData;

   fetch_queue #(
      .QDEPTH(QDEPTH)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_flush      (w_flush),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_pc    <= RESET_ADDR;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_set_fault) begin
            r_fault <= 1'b1;
         end
      end
   end

   // Redirect overrides everything else; fullness is the start-of-cycle value, so a pop cannot unblock a fetch.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      w_set_fault  = 1'b0;
      if (redirectValid) begin
         w_flush = 1'b1;
         if (w_redirect_ok) begin
            w_pc_next    = redirectPC;
            w_state_next = FETCH;
         end else begin
            w_set_fault  = 1'b1;
            w_state_next = HALTED;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (!w_full) begin
                  if (imemData == END_MARKER) begin
                     w_state_next = DRAIN;
                  end else begin
                     w_push    = 1'b1;
                     w_pc_next = w_pc_seq;
                  end
               end
            end
            DRAIN: begin
               if (w_drained) begin
                  w_state_next = HALTED;
               end
            end
            HALTED: begin
               w_state_next = HALTED;
            end
            default: begin
               w_state_next = FETCH;
            end
         endcase
      end
   end

   assign imemAddr    = r_pc;
   assign instrValid  = w_valid;
   assign instruction = w_valid ? w_head.word : '0;
   assign instrPC     = w_valid ? w_head.pc : '0;
   assign halted      = (r_state == HALTED);
   assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instruction;
   logic [31:0] instrPC;
   logic        halted;
   logic        fault;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic [31:0] mem [0:4095];
   exp_t        exp_q [$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   assign imemData = mem[imemAddr[13:2]];

   fetch_sequencer #(
      .RESET_PC  (100),
      .QDEPTH    (4),
      .MEM_BYTES (16384)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imemAddr      (imemAddr),
      .imemData      (imemData),
      .redirectValid (redirectValid),
      .redirectPC    (redirectPC),
      .instrValid    (instrValid),
      .instrReady    (instrReady),
      .instruction   (instruction),
      .instrPC       (instrPC),
      .halted        (halted),
      .fault         (fault)
   );

   // Every accepted head entry must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && instrValid && instrReady) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL stream_unexpected: got pc %0d word %h, required no instruction", instrPC, instruction);
         end else begin
            mon_e = exp_q.pop_front();
            if (instrPC !== mon_e.pc || instruction !== mon_e.word) begin
               n_errors++;
               $display("FAIL stream_entry: got pc %0d word %h, required pc %0d word %h",
                        instrPC, instruction, mon_e.pc, mon_e.word);
            end
         end
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 32'h0000_2083 + (32'(i) << 16);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = mem[pc[13:2]];
      exp_q.push_back(e);
   endtask

   task automatic hold_reset();
      rst_n         = 1'b0;
      redirectValid = 1'b0;
      redirectPC    = 32'd0;
      instrReady    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      fill_mem();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_halted();
      for (int i = 0; i < 80 && !halted; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      hold_reset();
      @(negedge clk);
      n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, required 0", instrValid); end
      n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b, required 0", halted); end
      n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b, required 0", fault); end
      n_checks++; if (imemAddr !== 32'd100) begin n_errors++; $display("FAIL reset_addr: got %0d, required 100", imemAddr); end
      n_checks++; if (instruction !== 32'd0) begin n_errors++; $display("FAIL reset_instr: got %h, required 0", instruction); end
      n_checks++; if (instrPC !== 32'd0) begin n_errors++; $display("FAIL reset_pc: got %0d, required 0", instrPC); end
   endtask

   task automatic test_stream();
      hold_reset();
      mem[33] = 32'h0;
      for (int a = 100; a <= 128; a += 4) push_exp(32'(a));
      instrReady = 1'b1;
      release_reset();
      @(negedge clk);
      n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL stream_early_valid: got %b, required 0", instrValid); end
      @(negedge clk);
      n_checks++; if (instrValid !== 1'b1 || instrPC !== 32'd100) begin
         n_errors++; $display("FAIL stream_latency: got valid %b pc %0d, required valid 1 pc 100", instrValid, instrPC);
      end
      wait_halted();
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL stream_halt: got %b, required 1", halted); end
      n_checks++; if (instrValid !== 1'b0) begin n_errors++; $display("FAIL stream_halt_valid: got %b, required 0", instrValid); end
      n_checks++; if (imemAddr !== 32'd132) begin n_errors++; $display("FAIL stream_halt_addr: got %0d, required 132", imemAddr); end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL stream_left: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [31:0] held_pc;
      hold_reset();
      mem[30] = 32'h0;
      release_reset();
      repeat (5) @(negedge clk);
      held_pc = instrPC;
      repeat (5) @(negedge clk);
      n_checks++; if (imemAddr !== 32'd116) begin n_errors++; $display("FAIL bp_addr: got %0d, required 116", imemAddr); end
      n_checks++; if (instrValid !== 1'b1 || instrPC !== 32'd100 || held_pc !== 32'd100) begin
         n_errors++; $display("FAIL bp_head_stable: got valid %b pc %0d earlier %0d, required 1/100/100", instrValid, instrPC, held_pc);
      end
      for (int a = 100; a <= 116; a += 4) push_exp(32'(a));
      @(posedge clk);
      #1 instrReady = 1'b1;
      wait_halted();
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL bp_halt: got %b, required 1", halted); end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL bp_left: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect();
      hold_reset();
      mem[153] = 32'h0;
      release_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (instrPC !== 32'd100 || imemAddr !== 32'd112) begin
         n_errors++; $display("FAIL redir_pre: got pc %0d addr %0d, required 100/112", instrPC, imemAddr);
      end
      push_exp(32'd100);
      push_exp(32'd600);
      push_exp(32'd604);
      push_exp(32'd608);
      instrReady    = 1'b1;
      redirectValid = 1'b1;
      redirectPC    = 32'd600;
      @(posedge clk);
      #1 redirectValid = 1'b0;
      @(negedge clk);
      n_checks++; if (instrValid !== 1'b0 || imemAddr !== 32'd600) begin
         n_errors++; $display("FAIL redir_flush: got valid %b addr %0d, required 0/600", instrValid, imemAddr);
      end
      wait_halted();
      n_checks++; if (exp_q.size() != 0 || halted !== 1'b1) begin
         n_errors++; $display("FAIL redir_left: got %0d pending halted %b, required 0/1", exp_q.size(), halted);
      end
   endtask

   task automatic test_fault();
      hold_reset();
      mem[52] = 32'h0;
      release_reset();
      repeat (2) @(posedge clk);
      #1 redirectValid = 1'b1;
      redirectPC = 32'd602;
      @(posedge clk);
      #1 redirectValid = 1'b0;
      @(negedge clk);
      n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || instrValid !== 1'b0) begin
         n_errors++; $display("FAIL fault_set: got fault %b halted %b valid %b, required 1/1/0", fault, halted, instrValid);
      end
      repeat (3) @(negedge clk);
      n_checks++; if (halted !== 1'b1 || instrValid !== 1'b0) begin
         n_errors++; $display("FAIL fault_hold: got halted %b valid %b, required 1/0", halted, instrValid);
      end
      push_exp(32'd200);
      push_exp(32'd204);
      instrReady = 1'b1;
      @(posedge clk);
      #1 redirectValid = 1'b1;
      redirectPC = 32'd200;
      @(posedge clk);
      #1 redirectValid = 1'b0;
      @(negedge clk);
      n_checks++; if (halted !== 1'b0 || fault !== 1'b1 || imemAddr !== 32'd200) begin
         n_errors++; $display("FAIL fault_resume: got halted %b fault %b addr %0d, required 0/1/200", halted, fault, imemAddr);
      end
      wait_halted();
      n_checks++; if (fault !== 1'b1 || exp_q.size() != 0) begin
         n_errors++; $display("FAIL fault_sticky: got fault %b pending %0d, required 1/0", fault, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      hold_reset();
      mem[2] = 32'h0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      redirectValid = 1'b1;
      redirectPC    = 32'd16380;
      @(posedge clk);
      #1 redirectValid = 1'b0;
      instrReady = 1'b1;
      push_exp(32'd16380);
      push_exp(32'd0);
      push_exp(32'd4);
      @(negedge clk);
      n_checks++; if (imemAddr !== 32'd16380) begin n_errors++; $display("FAIL wrap_start: got %0d, required 16380", imemAddr); end
      @(negedge clk);
      n_checks++; if (imemAddr !== 32'd0) begin n_errors++; $display("FAIL wrap_zero: got %0d, required 0", imemAddr); end
      wait_halted();
      n_checks++; if (exp_q.size() != 0 || halted !== 1'b1) begin
         n_errors++; $display("FAIL wrap_left: got %0d pending halted %b, required 0/1", exp_q.size(), halted);
      end
   endtask

   task automatic test_async_reset();
      hold_reset();
      release_reset();
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (instrValid !== 1'b1 || imemAddr !== 32'd116) begin
         n_errors++; $display("FAIL areset_full: got valid %b addr %0d, required 1/116", instrValid, imemAddr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (instrValid !== 1'b0 || imemAddr !== 32'd100 || instrPC !== 32'd0 || instruction !== 32'd0) begin
         n_errors++; $display("FAIL areset_clear: got valid %b addr %0d pc %0d instr %h, required 0/100/0/0",
                              instrValid, imemAddr, instrPC, instruction);
      end
      mem[27] = 32'h0;
      push_exp(32'd100);
      push_exp(32'd104);
      instrReady = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_halted();
      n_checks++; if (exp_q.size() != 0 || halted !== 1'b1) begin
         n_errors++; $display("FAIL areset_left: got %0d pending halted %b, required 0/1", exp_q.size(), halted);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      redirectValid = 1'b0;
      redirectPC    = 32'd0;
      instrReady    = 1'b0;
      fill_mem();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 100, byte address where fetch starts after reset.
REQ-002 Parameter QDEPTH, default 4, prefetch-queue entries (power of two, >=2).
REQ-003 Parameter MEM_BYTES, default 16384, instruction-memory size in bytes.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 imemAddr  output  32  byte address driven to instruction memory PC input.
REQ-007 imemData  input  32  instruction word, combinational from imemAddr, same cycle.
REQ-008 redirectValid  input  1  branch/jump redirect request.
REQ-009 redirectPC  input  32  redirect target byte address.
REQ-010 instrValid  output  1  queue head holds a valid instruction.
REQ-011 instrReady  input  1  consumer accepts head this cycle.
REQ-012 instruction  output  32  head instruction word.
REQ-013 instrPC  output  32  byte address of head instruction.
REQ-014 halted  output  1  sequencer in HALTED state.
REQ-015 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-016 States: FETCH, DRAIN, HALTED. imemAddr equals the internal fetch PC in every state.
REQ-017 FETCH, queue not full: push {PC, imemData}, PC <= PC+4 in the same edge.
REQ-018 PC+4 >= MEM_BYTES wraps PC to 0.
REQ-019 Queue full at start of cycle blocks the fetch, even if a pop occurs that cycle. PC holds.
REQ-020 Head handshake: entry removed on the edge where instrValid && instrReady. instruction/instrPC stable while instrValid && !instrReady.
REQ-021 Fetch-to-instrValid latency: 1 cycle (word fetched in cycle N visible at head in N+1 when the queue was empty).
REQ-022 Fetched word == 32'h00000000 (end marker): word is not pushed, PC holds, state -> DRAIN.
REQ-023 DRAIN: no fetches. When the queue becomes empty -> HALTED.
REQ-024 HALTED: no fetches, instrValid=0, halted=1.
REQ-025 redirectValid, redirectPC[1:0]==0, redirectPC < MEM_BYTES: queue flushed, PC <= redirectPC, state -> FETCH from any state. No push that cycle.
REQ-026 redirectValid with misaligned or out-of-range redirectPC: queue flushed, fault <= 1, state -> HALTED.
REQ-027 Redirect has priority over push, end-marker detection and pop.
REQ-028 A head handshake in the redirect cycle counts as accepted. All other entries are discarded.
REQ-029 Only a reset clears fault. A later valid redirect leaves HALTED but fault stays 1.
REQ-030 Occupancy counter width is clog2(QDEPTH)+1. Read/write pointers wrap modulo QDEPTH.

Reset
REQ-031 rst_n low asynchronously sets PC=RESET_PC, state=FETCH, queue empty, fault=0, instrValid=0, halted=0, instruction=0, instrPC=0.
REQ-032 Reset asserted mid-operation discards all queued entries. The first fetch after deassertion reads RESET_PC.

Structure
REQ-033 A shared package holds the state enumeration (FETCH, DRAIN, HALTED), the END_MARKER constant 32'h0 and the address width 32.
REQ-034 The prefetch queue is a sub-module fetch_queue (QDEPTH x 64-bit {PC, word}) with push/pop/flush, full and empty.

Verification
REQ-035 Reset, RESET_PC=100, memory bytes 100..131 hold eight lw words, instrReady=1: eight instructions, instrPC 100,104,...,128, first instrValid one cycle after reset release. The zero word at 132 leads to halted=1 after the queue drains.
REQ-036 instrReady=0 for 10 cycles from reset: exactly 4 fetches (PC 100..112), imemAddr holds 116. On instrReady=1 the order is 100,104,108,112,116.
REQ-037 Redirect to 600 while the queue holds 3 entries and the head is being accepted: the next instrPC is 600. No entry from the old stream appears afterwards.
REQ-038 redirectPC=602: fault=1, halted=1, instrValid=0 next cycle. A subsequent redirect to 200 resumes fetch at 200 with fault still 1.
REQ-039 PC=16380 with a nonzero word: the next imemAddr is 0.
REQ-040 rst_n pulsed low mid-stream with a full queue: instrValid=0 immediately (asynchronous), the first post-reset instrPC is 100.
